// File: rtl/and_input_driver.sv
// and_input_driver
// Stimulus source for the input side of an AND gate. Operand pairs arrive
// on a valid/ready command port and are buffered in a small FIFO. An FSM
// (IDLE / DRIVE / GAP) presents one pair per DRIVE cycle on registered a/b
// outputs, then inserts a programmable idle gap. One cycle after each drive,
// the expected AND result is published for the output-side checker.
//
// Optional build macro: AND_INPUT_DRIVER_STATS_EN
//   When defined, adds a 16-bit wrapping drv_count output that counts
//   cycles with drv_valid high.
module and_input_driver #(
  parameter int AND_INPUTS_WIDTH = 8,
  parameter int FIFO_DEPTH       = 4,
  parameter int GAP_WIDTH        = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic [AND_INPUTS_WIDTH-1:0]       cmd_a,
  input  logic [AND_INPUTS_WIDTH-1:0]       cmd_b,
  input  logic [GAP_WIDTH-1:0]              gap_cycles,
  output logic [AND_INPUTS_WIDTH-1:0]       a,
  output logic [AND_INPUTS_WIDTH-1:0]       b,
  output logic                              drv_valid,
  output logic [AND_INPUTS_WIDTH-1:0]       exp_y,
  output logic                              exp_valid,
  output logic [$clog2(FIFO_DEPTH):0]       fifo_count,
  output logic                              busy
`ifdef AND_INPUT_DRIVER_STATS_EN
  ,
  output logic [15:0]                       drv_count
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  // FIFO storage and bookkeeping
  logic [AND_INPUTS_WIDTH-1:0] r_mem_a [FIFO_DEPTH];
  logic [AND_INPUTS_WIDTH-1:0] r_mem_b [FIFO_DEPTH];
  logic [PTR_W-1:0]            r_wr_ptr;
  logic [PTR_W-1:0]            r_rd_ptr;
  logic [CNT_W-1:0]            r_count;

  // FSM
  state_t                      r_state;
  state_t                      w_state_next;
  logic [GAP_WIDTH-1:0]        r_gap_cnt;
  logic [GAP_WIDTH-1:0]        w_gap_cnt_next;

  // Drive-side registers
  logic [AND_INPUTS_WIDTH-1:0] r_a;
  logic [AND_INPUTS_WIDTH-1:0] r_b;
  logic [AND_INPUTS_WIDTH-1:0] r_exp_y;
  logic                        r_exp_valid;

  // Handshake and control wires
  logic                        w_full;
  logic                        w_empty;
  logic                        w_push;
  logic                        w_pop;
  logic                        w_drv_valid;
  logic [AND_INPUTS_WIDTH-1:0] w_head_a;
  logic [AND_INPUTS_WIDTH-1:0] w_head_b;

  // No push-through when full: ready depends only on occupancy, never on a pop
  assign w_full    = (r_count == FULL_CNT);
  assign w_empty   = (r_count == '0);
  assign w_push    = cmd_valid & ~w_full;
  assign w_head_a  = r_mem_a[r_rd_ptr];
  assign w_head_b  = r_mem_b[r_rd_ptr];

  // DRIVE lasts exactly one cycle per transaction, so drv_valid is the state
  assign w_drv_valid = (r_state == S_DRIVE);

  // Buffer write port; storage itself is not reset, only the pointers are
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_a[r_wr_ptr] <= cmd_a;
      r_mem_b[r_wr_ptr] <= cmd_b;
    end
  end

  // Pointer and occupancy tracking; pointers wrap naturally (depth is 2^n)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FSM state and gap counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_gap_cnt <= '0;
    end else begin
      r_state   <= w_state_next;
      r_gap_cnt <= w_gap_cnt_next;
    end
  end

  // Next-state logic; every transition into DRIVE pops the FIFO head
  always_comb begin
    w_state_next   = r_state;
    w_gap_cnt_next = r_gap_cnt;
    w_pop          = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_state_next = S_DRIVE;
          w_pop        = 1'b1;
        end
      end
      S_DRIVE: begin
        // gap_cycles is sampled only here; later changes cannot stretch a gap
        if (gap_cycles == '0) begin
          if (!w_empty) begin
            w_state_next = S_DRIVE;
            w_pop        = 1'b1;
          end else begin
            w_state_next = S_IDLE;
          end
        end else begin
          w_state_next   = S_GAP;
          w_gap_cnt_next = gap_cycles;
        end
      end
      S_GAP: begin
        // The counter holds the number of GAP cycles still to spend,
        // including the current one; <= 1 also guards a zero count.
        if (r_gap_cnt <= GAP_WIDTH'(1)) begin
          w_gap_cnt_next = '0;
          if (!w_empty) begin
            w_state_next = S_DRIVE;
            w_pop        = 1'b1;
          end else begin
            w_state_next = S_IDLE;
          end
        end else begin
          w_gap_cnt_next = r_gap_cnt - GAP_WIDTH'(1);
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Operand registers: load the FIFO head whenever it is popped, else hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a <= '0;
      r_b <= '0;
    end else if (w_pop) begin
      r_a <= w_head_a;
      r_b <= w_head_b;
    end
  end

  // Expected result trails the drive cycle by one; exp_y holds between drives
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_exp_y     <= '0;
      r_exp_valid <= 1'b0;
    end else begin
      r_exp_valid <= w_drv_valid;
      if (w_drv_valid) begin
        r_exp_y <= r_a & r_b;
      end
    end
  end

`ifdef AND_INPUT_DRIVER_STATS_EN
  logic [15:0] r_drv_count;

  // Count drive cycles; wraps modulo 2^16
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drv_count <= '0;
    end else if (w_drv_valid) begin
      r_drv_count <= r_drv_count + 16'd1;
    end
  end

  assign drv_count = r_drv_count;
`endif

  assign cmd_ready  = ~w_full;
  assign a          = r_a;
  assign b          = r_b;
  assign drv_valid  = w_drv_valid;
  assign exp_y      = r_exp_y;
  assign exp_valid  = r_exp_valid;
  assign fifo_count = r_count;
  assign busy       = (r_state != S_IDLE) | ~w_empty;

endmodule

// File: tb/tb_and_input_driver.sv
// Testbench for and_input_driver: directed stimulus, an event-timing model
// of the driver checked every cycle, and hand-computed literal checks.
`timescale 1ns/1ps
module tb_and_input_driver;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
  } pair_t;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic [3:0] gap_cycles;
  logic [7:0] a;
  logic [7:0] b;
  logic       drv_valid;
  logic [7:0] exp_y;
  logic       exp_valid;
  logic [2:0] fifo_count;
  logic       busy;
`ifdef AND_INPUT_DRIVER_STATS_EN
  logic [15:0] drv_count;
`endif

  and_input_driver #(
    .AND_INPUTS_WIDTH(8),
    .FIFO_DEPTH(DEPTH),
    .GAP_WIDTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_a(cmd_a),
    .cmd_b(cmd_b),
    .gap_cycles(gap_cycles),
    .a(a),
    .b(b),
    .drv_valid(drv_valid),
    .exp_y(exp_y),
    .exp_valid(exp_valid),
    .fifo_count(fifo_count),
    .busy(busy)
`ifdef AND_INPUT_DRIVER_STATS_EN
    ,
    .drv_count(drv_count)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, want, $time);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------------------------------------------------------------
  // Model: the queue of accepted-but-undriven pairs plus the edge index at
  // which the next drive may start. A drive ending at edge e with gap g
  // allows the next drive at edge e+g at the earliest.
  // ---------------------------------------------------------------------
  pair_t       mq[$];
  logic [7:0]  am = 8'h00;
  logic [7:0]  bm = 8'h00;
  logic [7:0]  eym = 8'h00;
  logic        drvm = 1'b0;
  logic        evm = 1'b0;
  logic [15:0] dcm = 16'h0000;
  int unsigned eidx = 0;
  int unsigned earliest = 0;
  int          msz;
  logic        mstart;
  pair_t       mp;
  pair_t       drv_log[$];

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        mq.delete();
        am = 8'h00; bm = 8'h00; eym = 8'h00;
        drvm = 1'b0; evm = 1'b0; dcm = 16'h0000;
        eidx = 0; earliest = 0;
      end else begin
        evm = drvm;
        if (drvm) begin
          eym = am & bm;
          dcm = dcm + 16'd1;
        end
        eidx++;
        if (drvm) earliest = eidx + 32'(gap_cycles);
        msz = mq.size();
        mstart = (msz != 0) && (eidx >= earliest);
        if (cmd_valid && msz != DEPTH) begin
          mp.a = cmd_a;
          mp.b = cmd_b;
          mq.push_back(mp);
        end
        if (mstart) begin
          mp = mq.pop_front();
          am = mp.a;
          bm = mp.b;
        end
        drvm = mstart;
      end
    end
  end

  // Compare the DUT against the model on every falling edge
  initial begin
    logic busy_m;
    pair_t lp;
    forever begin
      @(negedge clk);
      busy_m = drvm || (eidx < earliest) || (mq.size() != 0);
      chk("cmp_a", 32'(a), 32'(am));
      chk("cmp_b", 32'(b), 32'(bm));
      chk("cmp_drv_valid", 32'(drv_valid), 32'(drvm));
      chk("cmp_exp_valid", 32'(exp_valid), 32'(evm));
      chk("cmp_exp_y", 32'(exp_y), 32'(eym));
      chk("cmp_fifo_count", 32'(fifo_count), 32'(mq.size()));
      chk("cmp_cmd_ready", 32'(cmd_ready), 32'(mq.size() != DEPTH));
      chk("cmp_busy", 32'(busy), 32'(busy_m));
`ifdef AND_INPUT_DRIVER_STATS_EN
      chk("cmp_drv_count", 32'(drv_count), 32'(dcm));
`endif
      if (drv_valid) begin
        lp.a = a;
        lp.b = b;
        drv_log.push_back(lp);
      end
    end
  end

  // Present a command at a falling edge and hold it until accepted.
  // Returns at the falling edge after the accepting rising edge.
  task automatic push(input logic [7:0] pa, input logic [7:0] pb, input int budget);
    int   n;
    logic acc;
    logic done;
    n = 0;
    done = 1'b0;
    cmd_a = pa;
    cmd_b = pb;
    cmd_valid = 1'b1;
    while (!done && n < budget) begin
      acc = cmd_ready;
      @(posedge clk);
      n++;
      if (acc) done = 1'b1;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    chk("push_accepted", 32'(done), 32'd1);
  endtask

  task automatic wait_drv(input int budget);
    int n;
    n = 0;
    while (!drv_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wait_drv", 32'(drv_valid), 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog time=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] exp_seq [4];
    int n;
    int hits;
    exp_seq = '{8'h0F, 8'h00, 8'h81, 8'h00};

    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_a = 8'h00;
    cmd_b = 8'h00;
    gap_cycles = 4'd0;
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst_a", 32'(a), 32'h0);
    chk("rst_b", 32'(b), 32'h0);
    chk("rst_exp_y", 32'(exp_y), 32'h0);
    chk("rst_drv_valid", 32'(drv_valid), 32'h0);
    chk("rst_exp_valid", 32'(exp_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_fifo_count", 32'(fifo_count), 32'h0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'h1);
    rst = 1'b0;
    @(negedge clk);

    // Single command
    push(8'hF0, 8'h3C, 5);
    $display("T1 single command pushed a=f0 b=3c");
    chk("t1_count_after_accept", 32'(fifo_count), 32'd1);
    chk("t1_no_drive_yet", 32'(drv_valid), 32'd0);
    @(negedge clk);
    chk("t1_drv_valid", 32'(drv_valid), 32'd1);
    chk("t1_a", 32'(a), 32'hF0);
    chk("t1_b", 32'(b), 32'h3C);
    @(negedge clk);
    chk("t1_drv_one_cycle", 32'(drv_valid), 32'd0);
    chk("t1_exp_valid", 32'(exp_valid), 32'd1);
    chk("t1_exp_y", 32'(exp_y), 32'h30);
    @(negedge clk);
    chk("t1_idle_busy", 32'(busy), 32'd0);

    // Back-to-back: a warm-up drive with a long gap lets the FIFO fill
    gap_cycles = 4'd15;
    push(8'h12, 8'h34, 5);
    @(negedge clk);
    @(negedge clk);
    gap_cycles = 4'd0;
    push(8'hFF, 8'h0F, 5);
    push(8'hAA, 8'h55, 5);
    push(8'h81, 8'h81, 5);
    push(8'h00, 8'hFF, 5);
    $display("T2 four pairs pushed, fifo_count=%0d cmd_ready=%0d", fifo_count, cmd_ready);
    chk("t2_full_count", 32'(fifo_count), 32'd4);
    chk("t2_full_ready", 32'(cmd_ready), 32'd0);
    wait_drv(40);
    for (int i = 0; i < 5; i++) begin
      if (i < 4) chk("t2_b2b_drv", 32'(drv_valid), 32'd1);
      else chk("t2_b2b_end", 32'(drv_valid), 32'd0);
      if (i >= 1) begin
        chk("t2_exp_valid", 32'(exp_valid), 32'd1);
        chk("t2_exp_y", 32'(exp_y), 32'(exp_seq[i-1]));
      end
      @(negedge clk);
    end
    wait_idle(20);

    // Gap timing, with gap_cycles changed mid-gap
    gap_cycles = 4'd3;
    push(8'hC3, 8'h3C, 5);
    push(8'h0F, 8'hF0, 5);
    $display("T3 gap=3 two pairs pushed");
    chk("t3_first_drv", 32'(drv_valid), 32'd1);
    chk("t3_first_a", 32'(a), 32'hC3);
    @(negedge clk);
    gap_cycles = 4'd9;
    n = 0;
    while (!drv_valid && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("t3_gap_len", 32'(n), 32'd3);
    chk("t3_second_a", 32'(a), 32'h0F);
    wait_idle(30);
    gap_cycles = 4'd0;

    // Full and pointer wrap
    gap_cycles = 4'd15;
    push(8'h11, 8'h22, 5);
    @(negedge clk);
    @(negedge clk);
    drv_log.delete();
    for (int i = 0; i < 4; i++) push(8'hA1 + 8'(i), 8'hFF, 5);
    chk("t4_full_count", 32'(fifo_count), 32'd4);
    chk("t4_full_ready", 32'(cmd_ready), 32'd0);
    push(8'hA5, 8'hFF, 60);
    push(8'hA6, 8'hFF, 60);
    wait_idle(200);
    $display("T4 drained, %0d drives logged", drv_log.size());
    chk("t4_drive_count", 32'(drv_log.size()), 32'd6);
    for (int i = 0; i < 6 && i < drv_log.size(); i++) begin
      chk("t4_order_a", 32'(drv_log[i].a), 32'(8'hA1 + 8'(i)));
    end
    gap_cycles = 4'd0;

    // Reset mid-operation during GAP with two entries buffered
    gap_cycles = 4'd15;
    push(8'hF3, 8'h3F, 5);
    @(negedge clk);
    @(negedge clk);
    push(8'h55, 8'hAA, 5);
    push(8'h66, 8'h99, 5);
    chk("t5_pre_exp_y", 32'(exp_y), 32'h33);
    #3 rst = 1'b1;
    #1;
    $display("T5 async reset asserted");
    chk("t5_rst_a", 32'(a), 32'h0);
    chk("t5_rst_b", 32'(b), 32'h0);
    chk("t5_rst_exp_y", 32'(exp_y), 32'h0);
    chk("t5_rst_count", 32'(fifo_count), 32'h0);
    chk("t5_rst_busy", 32'(busy), 32'h0);
    chk("t5_rst_ready", 32'(cmd_ready), 32'h1);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    gap_cycles = 4'd0;
    hits = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (drv_valid) hits++;
    end
    chk("t5_quiet_after_reset", 32'(hits), 32'd0);
    push(8'h77, 8'hEE, 5);
    @(negedge clk);
    chk("t5_new_drv", 32'(drv_valid), 32'd1);
    chk("t5_new_a", 32'(a), 32'h77);
    wait_idle(10);

`ifdef AND_INPUT_DRIVER_STATS_EN
    // Drive counter wrap
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drv_log.delete();
    gap_cycles = 4'd0;
    for (int i = 0; i < 65534; i++) push(8'(i), 8'hFF, 5);
    wait_idle(10);
    drv_log.delete();
    chk("t6_preload", 32'(drv_count), 32'hFFFE);
    push(8'h01, 8'h01, 5);
    push(8'h02, 8'h02, 5);
    push(8'h03, 8'h03, 5);
    chk("t6_count_ffff", 32'(drv_count), 32'hFFFF);
    @(negedge clk);
    chk("t6_count_0000", 32'(drv_count), 32'h0000);
    @(negedge clk);
    chk("t6_count_0001", 32'(drv_count), 32'h0001);
    $display("T6 drv_count wrap sequence observed, now=%0h", drv_count);
    wait_idle(10);
`endif

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/and_input_driver.md
Name: and_input_driver

Overview:
- Synthesizable stimulus source for the AND gate input side; the counterpart of the AND_output monitor/responder path.
- Accepts operand pairs over a valid/ready command port and buffers them in a small FIFO.
- Drives operand pairs onto the AND gate inputs one per DRIVE cycle, with a programmable idle gap between transactions.
- Publishes the expected y one cycle later, for the output-side checker.

Parameters:
- AND_INPUTS_WIDTH, 8, width of operands a, b and result y.
- FIFO_DEPTH, 4, command buffer entries; power of two, >= 2.
- GAP_WIDTH, 4, width of gap_cycles; maximum gap is 2^GAP_WIDTH-1 cycles.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  FIFO can accept; equals !full.
- cmd_a  input  AND_INPUTS_WIDTH  operand a.
- cmd_b  input  AND_INPUTS_WIDTH  operand b.
- gap_cycles  input  GAP_WIDTH  idle cycles inserted after each DRIVE.
- a  output  AND_INPUTS_WIDTH  AND gate input a (registered).
- b  output  AND_INPUTS_WIDTH  AND gate input b (registered).
- drv_valid  output  1  a/b carry a new transaction this cycle.
- exp_y  output  AND_INPUTS_WIDTH  expected result, a & b (registered).
- exp_valid  output  1  exp_y valid; drv_valid delayed by one cycle.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  entries currently buffered.
- busy  output  1  state != IDLE or fifo_count != 0.

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE and the FIFO empties; any buffered or in-flight transaction is dropped.
  - a, b, exp_y = 0; drv_valid, exp_valid, busy = 0; fifo_count = 0; cmd_ready = 1.
  - Outputs take these values immediately on rst assertion.
  - Normal operation resumes on the first rising edge after deassertion.
- Command accept: a push occurs at a rising edge when cmd_valid && cmd_ready.
  - When full, cmd_ready = 0 even if a pop happens in the same cycle; there is no push-through when full.
  - Simultaneous push and pop when not full leaves fifo_count unchanged.
- FIFO pointers wrap modulo FIFO_DEPTH; full when fifo_count == FIFO_DEPTH.
- FSM states: IDLE, DRIVE, GAP.
  - IDLE: if fifo_count != 0 at the edge, go to DRIVE, load a/b from the FIFO head and pop. Otherwise stay; a/b hold their last values.
  - DRIVE: drv_valid = 1 for exactly one cycle. At the next edge gap_cycles is sampled into gap_cnt:
    - gap_cycles == 0 and FIFO non-empty: stay in DRIVE, load next entry, pop (back-to-back).
    - gap_cycles == 0 and FIFO empty: go to IDLE.
    - gap_cycles != 0: go to GAP with gap_cnt = gap_cycles.
  - GAP: gap_cnt decrements each cycle. After exactly the sampled number of GAP cycles, go to DRIVE if the FIFO is non-empty, else IDLE. Changes to gap_cycles during GAP are ignored.
- Latency: a command accepted at edge E0 into an empty FIFO while IDLE gives drv_valid high between E1 and E2.
- Expected result: exp_y <= a & b and exp_valid <= drv_valid, both registered on the edge ending the DRIVE cycle. exp_y holds its value when exp_valid is low.
- drv_valid never asserts on consecutive cycles unless gap_cycles == 0.

Optional Feature:
- Macro: AND_INPUT_DRIVER_STATS_EN.
- When defined, adds output drv_count, 16 bits:
  - Increments on every cycle drv_valid = 1.
  - Wraps from 0xFFFF to 0x0000.
  - Reset to 0 by rst.
- When undefined, the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Single command: rst pulse, push a=0xF0, b=0x3C, gap=0 → drv_valid exactly one cycle after the accept edge with a=0xF0, b=0x3C; next cycle exp_valid=1, exp_y=0x30; then IDLE with busy=0.
- Back-to-back: push 4 pairs (0xFF&0x0F, 0xAA&0x55, 0x81&0x81, 0x00&0xFF) with gap=0 → cmd_ready low after the 4th accept; four consecutive drv_valid cycles; exp_y sequence 0x0F, 0x00, 0x81, 0x00.
- Gap timing: gap=3, push 2 pairs → exactly 3 cycles with drv_valid=0 between the two drv_valid pulses; changing gap during GAP has no effect.
- Full/wrap: push 6 commands while gap=15 holds the FSM → only 4 are accepted (fifo_count=4, cmd_ready=0). The remaining 2 are accepted as the FIFO drains, crossing the pointer wrap. All 6 are driven in order.
- Reset mid-operation: assert rst asynchronously (off-edge) during GAP with 2 entries buffered → a, b, exp_y, fifo_count go to 0 immediately; no further drv_valid after deassertion until new commands are pushed.
- Stats (AND_INPUT_DRIVER_STATS_EN): preload so drv_count=0xFFFE, drive 3 transactions → 0xFFFF, 0x0000, 0x0001.
